ext_unit: RTL and testbench

Parametrised, pipelined operand extension unit for the datapath. It replaces the fixed 16→32 sign extender and adds several capabilities: zero-extend and upper-immediate (LUI) modes, plus byte/halfword load alignment with sign or zero extension. Results are registered and pass through a 2-entry output buffer with valid/ready handshakes. It sits between the memory read port or decoder immediate field and the writeback/ALU operand mux.

---
 rtl/ext_pkg.sv | 19 +
 rtl/ext_core.sv | 59 +++++
 rtl/ext_unit.sv | 86 ++++++++
 tb/tb_ext_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
`default_nettype none
//==============================================================================
// Module   : ext_pkg
// Desc     : Shared operation codes for the operand extension unit.
// Revision : 1.0 - initial release
//==============================================================================
package ext_pkg;

    localparam logic [2:0] EXT_LB   = 3'd0;
    localparam logic [2:0] EXT_LBU  = 3'd1;
    localparam logic [2:0] EXT_LH   = 3'd2;
    localparam logic [2:0] EXT_LHU  = 3'd3;
    localparam logic [2:0] EXT_LW   = 3'd4;
    localparam logic [2:0] EXT_IMMS = 3'd5;
    localparam logic [2:0] EXT_IMMZ = 3'd6;
    localparam logic [2:0] EXT_LUI  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/ext_core.sv
`default_nettype none
//==============================================================================
// Module   : ext_core
// Desc     : Combinational byte/halfword alignment and sign/zero/LUI extension.
// Revision : 1.0 - initial release
//==============================================================================
module ext_core
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic [2:0]        i_mode,
    input  logic [OFF_W-1:0]  i_off,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_err
);

    localparam logic [OFF_W-1:0] c_half_max = OFF_W'(DATA_W/8 - 2);

    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [IMM_W-1:0] w_imm;
    logic             w_half_bad;

    // Shift the addressed byte down to bit 0 rather than using an indexed slice
    assign w_byte     = 8'(i_data >> {i_off, 3'b000});
    assign w_half     = 16'(i_data >> {i_off, 3'b000});
    assign w_imm      = i_data[IMM_W-1:0];
    assign w_half_bad = i_off[0] || (i_off > c_half_max);

    always_comb begin
        o_data = '0;
        o_err  = 1'b0;
        case (i_mode)
            EXT_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            EXT_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
            EXT_LH: begin
                if (w_half_bad) o_err = 1'b1;
                else            o_data = {{(DATA_W-16){w_half[15]}}, w_half};
            end
            EXT_LHU: begin
                if (w_half_bad) o_err = 1'b1;
                else            o_data = {{(DATA_W-16){1'b0}}, w_half};
            end
            EXT_LW: begin
                if (i_off != '0) o_err = 1'b1;
                else             o_data = i_data;
            end
            EXT_IMMS: o_data = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
            EXT_IMMZ: o_data = {{(DATA_W-IMM_W){1'b0}}, w_imm};
            default:  o_data = {w_imm, {(DATA_W-IMM_W){1'b0}}};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ext_unit.sv
`default_nettype none
//==============================================================================
// Module   : ext_unit
// Desc     : Operand extension unit with a 2-entry valid/ready output buffer.
// Revision : 1.0 - initial release
//==============================================================================
module ext_unit
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } ext_res_t;

    logic [DATA_W-1:0] w_core_data;
    logic              w_core_err;
    ext_res_t          w_res;
    ext_res_t          r_slot0;
    ext_res_t          r_slot1;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .OFF_W  (OFF_W)
    ) u_core (
        .i_mode (in_mode),
        .i_off  (in_off),
        .i_data (in_data),
        .o_data (w_core_data),
        .o_err  (w_core_err)
    );

    assign w_res     = {w_core_data, w_core_err};
    assign in_ready  = !rst && (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_slot0.data;
    assign out_err   = r_slot0.err;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // slot0 is always the head; slot1 is kept zero whenever it is not occupied
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_slot0 <= w_res;
                    else                 r_slot1 <= w_res;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_slot0 <= r_slot1;
                    r_slot1 <= '0;
                    r_count <= r_count - 2'd1;
                end
                2'b11:   r_slot0 <= w_res;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_unit.sv
`default_nettype none
//==============================================================================
// Module   : tb_ext_unit
// Desc     : Self-checking bench for ext_unit at DATA_W=32 and DATA_W=64.
// Revision : 1.0 - initial release
//==============================================================================
module tb_ext_unit;
    import ext_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]  in_mode;
    logic [1:0]  in_off;
    logic [31:0] in_data, out_data;

    logic        v64, rdy64, ov64, ordy64, oe64;
    logic [2:0]  mode64, off64;
    logic [63:0] data64, od64;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;
    exp_t q[$];

    ext_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_off(in_off), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    ext_unit #(.DATA_W(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64),
        .in_mode(mode64), .in_off(off64), .in_data(data64),
        .out_valid(ov64), .out_ready(ordy64),
        .out_data(od64), .out_err(oe64)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour expressed as byte/halfword arithmetic on integers
    function automatic void model(input int w, input logic [2:0] m, input int off,
                                  input logic [63:0] d, output logic [63:0] rd, output logic re);
        longint unsigned mask, x, v, imm;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        x    = d >> (8 * off);
        imm  = d & 64'hFFFF;
        rd   = 64'd0;
        re   = 1'b0;
        case (m)
            3'd0: begin v = x & 255; rd = (v >= 128) ? ((v - 256) & mask) : v; end
            3'd1: rd = x & 255;
            3'd2, 3'd3: begin
                if ((off % 2) != 0 || off > w/8 - 2) re = 1'b1;
                else begin
                    v  = x & 65535;
                    rd = (m == 3'd2 && v >= 32768) ? ((v - 65536) & mask) : v;
                end
            end
            3'd4: if (off != 0) re = 1'b1; else rd = d & mask;
            3'd5: rd = (imm >= 32768) ? ((imm - 65536) & mask) : imm;
            3'd6: rd = imm;
            default: rd = (imm << (w - 16)) & mask;
        endcase
    endfunction

    // One clock of the 32-bit unit: check current outputs, clock, update scoreboard
    task automatic cycle();
        logic [63:0] rd;
        logic        re;
        bit          acc, pop;
        #1;
        chk("in_ready", in_ready, (!rst && q.size() != 2));
        chk("out_valid", out_valid, (q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_err", out_err, q[0].e);
        end
        acc = in_valid && !rst && (q.size() != 2);
        pop = !rst && (q.size() != 0) && out_ready;
        model(32, in_mode, in_off, in_data, rd, re);
        @(posedge clk);
        if (rst) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{rd[31:0], re});
        end
        #1;
    endtask

    task automatic d32(input string tag, input logic [2:0] m, input logic [1:0] o,
                       input logic [31:0] d, input logic [31:0] ed, input logic ee);
        in_mode = m; in_off = o; in_data = d; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk({tag, "_data"}, out_data, ed);
        chk({tag, "_err"}, out_err, ee);
        cycle();
    endtask

    task automatic d64(input string tag, input logic [2:0] m, input logic [2:0] o,
                       input logic [63:0] d, input logic [63:0] ed, input logic ee);
        mode64 = m; off64 = o; data64 = d; v64 = 1'b1;
        #1 chk({tag, "_rdy"}, rdy64, 64'd1);
        @(posedge clk); #1;
        v64 = 1'b0;
        chk({tag, "_valid"}, ov64, 64'd1);
        chk({tag, "_data"}, od64, ed);
        chk({tag, "_err"}, oe64, ee);
        @(posedge clk); #1;
        chk({tag, "_drain"}, ov64, 64'd0);
    endtask

    initial begin
        logic [63:0] rd;
        logic        re;
        logic [2:0]  m;
        logic [2:0]  o;
        logic [63:0] d;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_mode = 3'd0; in_off = 2'd0; in_data = 32'd0;
        v64 = 1'b0; ordy64 = 1'b1; mode64 = 3'd0; off64 = 3'd0; data64 = 64'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_err", out_err, 64'd0);
        chk("rst_in_ready", in_ready, 64'd0);
        rst = 1'b0;
        #1 chk("rst_release_in_ready", in_ready, 64'd1);

        // Immediate modes
        d32("imms", EXT_IMMS, 2'd3, 32'h0000_8001, 32'hFFFF_8001, 1'b0);
        d32("immz", EXT_IMMZ, 2'd1, 32'h0000_8001, 32'h0000_8001, 1'b0);
        d32("lui",  EXT_LUI,  2'd2, 32'h0000_8001, 32'h8001_0000, 1'b0);
        // Load modes
        d32("lb2",  EXT_LB,  2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF, 1'b0);
        d32("lbu3", EXT_LBU, 2'd3, 32'h80FF_7F01, 32'h0000_0080, 1'b0);
        d32("lb1",  EXT_LB,  2'd1, 32'h80FF_7F01, 32'h0000_007F, 1'b0);
        d32("lh0",  EXT_LH,  2'd0, 32'h80FF_7F01, 32'h0000_7F01, 1'b0);
        d32("lh2",  EXT_LH,  2'd2, 32'h80FF_7F01, 32'hFFFF_80FF, 1'b0);
        d32("lhu2", EXT_LHU, 2'd2, 32'h80FF_7F01, 32'h0000_80FF, 1'b0);
        d32("lw0",  EXT_LW,  2'd0, 32'h80FF_7F01, 32'h80FF_7F01, 1'b0);
        // Misalignment
        d32("lh1",  EXT_LH,  2'd1, 32'h80FF_7F01, 32'h0000_0000, 1'b1);
        d32("lhu3", EXT_LHU, 2'd3, 32'h80FF_7F01, 32'h0000_0000, 1'b1);
        d32("lw2",  EXT_LW,  2'd2, 32'h80FF_7F01, 32'h0000_0000, 1'b1);
        d32("imms_after_err", EXT_IMMS, 2'd1, 32'h0000_1234, 32'h0000_1234, 1'b0);

        // Backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_mode = EXT_IMMZ; in_off = 2'd0;
        in_data = 32'h1111; cycle();
        in_data = 32'h2222; cycle();
        in_data = 32'h3333;
        #1 chk("bp_full_in_ready", in_ready, 64'd0);
        cycle();
        chk("bp_hold_data", out_data, 64'h1111);
        cycle();
        chk("bp_hold_data2", out_data, 64'h1111);
        chk("bp_hold_err", out_err, 64'd0);
        out_ready = 1'b1; cycle();
        chk("bp_second", out_data, 64'h2222);
        chk("bp_ready_back", in_ready, 64'd1);
        cycle();
        chk("bp_third", out_data, 64'h3333);
        in_valid = 1'b0; cycle();
        chk("bp_drained", out_valid, 64'd0);

        // Streaming
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_mode = 3'($urandom_range(0, 7));
            in_off  = 2'($urandom_range(0, 3));
            in_data = $urandom;
            cycle();
        end
        in_valid = 1'b0; cycle();

        // Reset with the buffer full and a request pending
        out_ready = 1'b0; in_valid = 1'b1; in_mode = EXT_IMMZ; in_data = 32'hABCD;
        cycle(); cycle();
        #1 chk("pre_rst_full", in_ready, 64'd0);
        rst = 1'b1; in_data = 32'h5555;
        cycle();
        chk("midrst_out_valid", out_valid, 64'd0);
        chk("midrst_out_data", out_data, 64'd0);
        chk("midrst_out_err", out_err, 64'd0);
        chk("midrst_in_ready", in_ready, 64'd0);
        rst = 1'b0;
        d32("post_rst_lb", EXT_LB, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF, 1'b0);

        // Random traffic with random backpressure
        for (int i = 0; i < 200; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_mode   = 3'($urandom_range(0, 7));
            in_off    = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle(); cycle(); cycle();

        // Wide datapath
        d64("w_lh6",  EXT_LH,   3'd6, 64'h8899_AABB_80FF_7F01, 64'hFFFF_FFFF_FFFF_8899, 1'b0);
        d64("w_lh7",  EXT_LH,   3'd7, 64'h8899_AABB_80FF_7F01, 64'h0, 1'b1);
        d64("w_lh2",  EXT_LH,   3'd2, 64'h8899_AABB_80FF_7F01, 64'hFFFF_FFFF_FFFF_80FF, 1'b0);
        d64("w_lb5",  EXT_LB,   3'd5, 64'h8899_AABB_80FF_7F01, 64'hFFFF_FFFF_FFFF_FFAA, 1'b0);
        d64("w_lbu7", EXT_LBU,  3'd7, 64'h8899_AABB_80FF_7F01, 64'h88, 1'b0);
        d64("w_lw0",  EXT_LW,   3'd0, 64'h8899_AABB_80FF_7F01, 64'h8899_AABB_80FF_7F01, 1'b0);
        d64("w_lw4",  EXT_LW,   3'd4, 64'h8899_AABB_80FF_7F01, 64'h0, 1'b1);
        d64("w_imms", EXT_IMMS, 3'd3, 64'h8001, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
        d64("w_immz", EXT_IMMZ, 3'd3, 64'h8001, 64'h8001, 1'b0);
        d64("w_lui",  EXT_LUI,  3'd3, 64'h8001, 64'h8001_0000_0000_0000, 1'b0);
        for (int i = 0; i < 12; i++) begin
            m = 3'($urandom_range(0, 7));
            o = 3'($urandom_range(0, 7));
            d = {$urandom, $urandom};
            model(64, m, int'(o), d, rd, re);
            d64("w_rand", m, o, d, rd, re);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
